mem_access_stage: RTL and testbench

Memory-access pipeline stage directly downstream of the execute stage. It consumes the EX/MEM-registered ALU result (effective address), store data, access type and exception code. It then drives the data-cache SRAM-like request/response handshake and produces sign/zero-extended load data for write-back. The stage detects address-alignment exceptions and stalls the pipeline until the cache responds.

---
 rtl/mem_pkg.sv | 81 ++++++++
 rtl/load_extend.sv | 38 +++
 rtl/mem_access_stage.sv | 150 +++++++++++++++
 tb/tb_mem_access_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings, request record and helpers for the memory-access stage
package mem_pkg;

    localparam logic [2:0] MRT_WORD  = 3'd0;
    localparam logic [2:0] MRT_HALF  = 3'd1;
    localparam logic [2:0] MRT_HALFU = 3'd2;
    localparam logic [2:0] MRT_BYTE  = 3'd3;
    localparam logic [2:0] MRT_BYTEU = 3'd4;

    localparam logic [3:0] EXC_NONE = 4'd0;
    localparam logic [3:0] EXC_ADEL = 4'd4;
    localparam logic [3:0] EXC_ADES = 4'd5;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_CANCEL = 3'd4
    } mem_state_t;

    // Everything the cache sees for one request, plus the load type needed
    // later to extend the response.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [2:0]  rtype;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    function automatic logic is_misaligned(input logic [2:0] rtype, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (rtype)
            MRT_WORD:            mis = (offset != 2'b00);
            MRT_HALF, MRT_HALFU: mis = offset[0];
            default:             mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte and halfword stores replicate the datum on every lane so the strobes
    // alone pick the destination bytes.
    function automatic mem_req_t build_req(input logic wr, input logic [2:0] rtype,
                                           input logic [31:0] addr, input logic [31:0] wdata);
        mem_req_t r;
        r.wr    = wr;
        r.rtype = rtype;
        r.addr  = addr;
        r.wdata = wdata;
        r.size  = SIZE_WORD;
        r.wstrb = 4'b1111;
        case (rtype)
            MRT_HALF, MRT_HALFU: begin
                r.size  = SIZE_HALF;
                r.wdata = {2{wdata[15:0]}};
                r.wstrb = addr[1] ? 4'b1100 : 4'b0011;
            end
            MRT_BYTE, MRT_BYTEU: begin
                r.size  = SIZE_BYTE;
                r.wdata = {4{wdata[7:0]}};
                r.wstrb = 4'b0001 << addr[1:0];
            end
            default: begin
                r.size = SIZE_WORD;
                r.addr = {addr[31:2], 2'b00};
            end
        endcase
        if (!wr) begin
            r.wstrb = 4'b0000;
        end
        return r;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane select and sign/zero extension of cache read data
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  rtype,
    output logic [31:0] data
);

    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    // Pick the addressed halfword and byte lanes (little-endian).
    always_comb begin
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        byte_lane = rdata[7:0];
        case (offset)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
    end

    // Extend the selected lane according to the access type.
    always_comb begin
        data = rdata;
        case (rtype)
            MRT_HALF:  data = {{16{half_lane[15]}}, half_lane};
            MRT_HALFU: data = {16'h0000, half_lane};
            MRT_BYTE:  data = {{24{byte_lane[7]}}, byte_lane};
            MRT_BYTEU: data = {24'h000000, byte_lane};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access pipeline stage driving the data-cache handshake
module mem_access_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  MemReadType_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  exception_i,
    input  logic        flush,
    input  logic        pipe_stall,
    output logic        stall_o,
    output logic [31:0] load_data,
    output logic [3:0]  exception_o,
    output logic [31:0] bad_vaddr,
    output logic        d_req,
    output logic        d_wr,
    output logic [1:0]  d_size,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    output logic [3:0]  d_wstrb,
    input  logic        d_addr_ok,
    input  logic        d_data_ok,
    input  logic [31:0] d_rdata
);

    mem_state_t  state_q, state_n;
    mem_req_t    req_q, req_live, req_out;
    logic        flush_seen_q;
    logic [31:0] held_q;
    logic [31:0] ext_data;
    logic        mem_op, misaligned, access;

    assign mem_op     = MemRead_i | MemWrite_i;
    assign misaligned = mem_op & is_misaligned(MemReadType_i, addr_i[1:0]);
    assign access     = valid_i & mem_op & (exception_i == EXC_NONE) & ~misaligned & ~flush;
    assign req_live   = build_req(MemWrite_i & ~MemRead_i, MemReadType_i, addr_i, wdata_i);

    // Extension always works from the latched request, never the live inputs.
    load_extend u_load_extend (
        .rdata  (d_rdata),
        .offset (req_q.addr[1:0]),
        .rtype  (req_q.rtype),
        .data   (ext_data)
    );

    // Upstream exceptions win; otherwise flag misaligned loads/stores with the faulting address.
    always_comb begin
        exception_o = EXC_NONE;
        bad_vaddr   = 32'h0;
        if (valid_i && !flush) begin
            if (exception_i != EXC_NONE) begin
                exception_o = exception_i;
            end else if (misaligned) begin
                exception_o = MemRead_i ? EXC_ADEL : EXC_ADES;
                bad_vaddr   = addr_i;
            end
        end
    end

    // State, latched request, pending-flush flag and held load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            flush_seen_q <= 1'b0;
            held_q       <= 32'h0;
        end else begin
            state_q <= state_n;
            if (state_q == ST_IDLE && access) begin
                req_q <= req_live;
            end
            if (state_q == ST_IDLE) begin
                flush_seen_q <= 1'b0;
            end else if (state_q == ST_REQ && flush) begin
                flush_seen_q <= 1'b1;
            end
            if (state_q == ST_WAIT && d_data_ok) begin
                held_q <= ext_data;
            end
        end
    end

    // Next state and handshake/stall/result outputs.
    always_comb begin
        state_n   = state_q;
        d_req     = 1'b0;
        stall_o   = 1'b0;
        load_data = 32'h0;
        req_out   = req_q;
        case (state_q)
            ST_IDLE: begin
                req_out = req_live;
                if (access) begin
                    d_req   = 1'b1;
                    stall_o = 1'b1;
                    state_n = d_addr_ok ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                d_req   = 1'b1;
                stall_o = 1'b1;
                if (d_addr_ok) begin
                    state_n = (flush_seen_q || flush) ? ST_CANCEL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (d_data_ok) begin
                    if (flush) begin
                        state_n = ST_IDLE;
                    end else begin
                        load_data = ext_data;
                        state_n   = pipe_stall ? ST_HOLD : ST_IDLE;
                    end
                end else begin
                    stall_o = 1'b1;
                    if (flush) begin
                        state_n = ST_CANCEL;
                    end
                end
            end
            ST_HOLD: begin
                load_data = held_q;
                if (flush || !pipe_stall) begin
                    state_n = ST_IDLE;
                end
            end
            ST_CANCEL: begin
                stall_o = 1'b1;
                if (d_data_ok) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign d_wr    = req_out.wr;
    assign d_size  = req_out.size;
    assign d_addr  = req_out.addr;
    assign d_wdata = req_out.wdata;
    assign d_wstrb = req_out.wstrb;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage with cache responder model
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, MemRead_i, MemWrite_i;
    logic [2:0]  MemReadType_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  exception_i;
    logic        flush, pipe_stall;
    logic        stall_o;
    logic [31:0] load_data;
    logic [3:0]  exception_o;
    logic [31:0] bad_vaddr;
    logic        d_req, d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .MemReadType_i(MemReadType_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .exception_i(exception_i), .flush(flush),
        .pipe_stall(pipe_stall), .stall_o(stall_o), .load_data(load_data),
        .exception_o(exception_o), .bad_vaddr(bad_vaddr), .d_req(d_req),
        .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .d_rdata(d_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        req;
        logic        chk_out;
        logic        chk_ld;
        logic [31:0] ld;
        logic [3:0]  exc;
        logic [31:0] bad;
        string       tag;
    } cyc_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        string       tag;
    } req_t;

    cyc_t cq[$];
    req_t rq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [2:0] t);
        logic [31:0] v;
        int unsigned x;
        int          sh;
        sh = 8 * int'(off);
        v  = rdata >> sh;
        case (t)
            3'd0: return rdata;
            3'd1: begin
                x = v & 32'hFFFF;
                return (x >= 32768) ? x - 65536 : x;
            end
            3'd2: return v & 32'hFFFF;
            3'd3: begin
                x = v & 32'hFF;
                return (x >= 128) ? x - 256 : x;
            end
            default: return v & 32'hFF;
        endcase
    endfunction

    function automatic req_t ref_req(input logic wr, input logic [2:0] t, input logic [31:0] addr,
                                     input logic [31:0] wd, input string tag);
        req_t r;
        int   off;
        off    = int'(addr[1:0]);
        r.wr   = wr;
        r.tag  = tag;
        r.addr = addr;
        if (t == 3'd0) begin
            r.size  = 2'd2;
            r.addr  = addr & 32'hFFFF_FFFC;
            r.wdata = wd;
            r.wstrb = 4'hF;
        end else if (t <= 3'd2) begin
            r.size  = 2'd1;
            r.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
            r.wstrb = (off == 2) ? 4'hC : 4'h3;
        end else begin
            r.size  = 2'd0;
            r.wdata = (wd & 32'hFF) * 32'h0101_0101;
            r.wstrb = 4'(1 << off);
        end
        return r;
    endfunction

    // Monitor: pop the expectation for this cycle and compare away from the active edge.
    always @(negedge clk) begin : monitor
        cyc_t e;
        req_t r;
        if (!rst) begin
            if (cq.size() > 0) begin
                e = cq.pop_front();
                check32({e.tag, " stall_o"}, 32'(stall_o), 32'(e.stall));
                check32({e.tag, " d_req"}, 32'(d_req), 32'(e.req));
                if (e.chk_out) begin
                    check32({e.tag, " exception_o"}, 32'(exception_o), 32'(e.exc));
                    check32({e.tag, " bad_vaddr"}, bad_vaddr, e.bad);
                end
                if (e.chk_ld) begin
                    check32({e.tag, " load_data"}, load_data, e.ld);
                end
            end
            if (d_req && d_addr_ok) begin
                if (rq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected request: addr 0x%08h accepted, none expected", d_addr);
                end else begin
                    r = rq.pop_front();
                    check32({r.tag, " d_wr"}, 32'(d_wr), 32'(r.wr));
                    check32({r.tag, " d_size"}, 32'(d_size), 32'(r.size));
                    check32({r.tag, " d_addr"}, d_addr, r.addr);
                    if (r.wr) begin
                        check32({r.tag, " d_wdata"}, d_wdata, r.wdata);
                        check32({r.tag, " d_wstrb"}, 32'(d_wstrb), 32'(r.wstrb));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cyc(input logic stall, input logic req, input logic chk_out,
                            input logic chk_ld, input logic [31:0] ld, input logic [3:0] exc,
                            input logic [31:0] bad, input string tag);
        cyc_t e;
        e.stall = stall; e.req = req; e.chk_out = chk_out; e.chk_ld = chk_ld;
        e.ld = ld; e.exc = exc; e.bad = bad; e.tag = tag;
        cq.push_back(e);
    endtask

    task automatic clear_inputs();
        valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; MemReadType_i = 3'd0;
        addr_i = 32'h0; wdata_i = 32'h0; exception_i = 4'd0; flush = 1'b0;
        pipe_stall = 1'b0; d_addr_ok = 1'b0; d_data_ok = 1'b0; d_rdata = 32'h0;
    endtask

    task automatic idle_cycle();
        clear_inputs();
        d_rdata = $urandom;
        push_cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 4'd0, 32'h0, "idle");
        step();
    endtask

    // kind: 0 = non-memory, 1 = load, 2 = store. a = addr_ok delay, b = data_ok
    // distance after addr_ok (>=1), ps = cycles pipe_stall is high from data_ok.
    task automatic run_instr(input string tag, input int kind, input logic [2:0] t,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] exc_in, input int a, input int b, input int ps,
                             input logic [31:0] rdata);
        logic        mis, ld, st, access;
        logic [3:0]  exc_exp;
        logic [31:0] bad_exp, ld_exp;
        ld  = (kind == 1);
        st  = (kind == 2);
        mis = (t == 3'd0) ? (addr[1:0] != 2'b00) : ((t == 3'd1 || t == 3'd2) ? addr[0] : 1'b0);
        exc_exp = exc_in;
        bad_exp = 32'h0;
        if (exc_in == 4'd0 && (ld || st) && mis) begin
            exc_exp = ld ? 4'd4 : 4'd5;
            bad_exp = addr;
        end
        access = (ld || st) && exc_in == 4'd0 && !mis;
        clear_inputs();
        valid_i = 1'b1; MemRead_i = ld; MemWrite_i = st; MemReadType_i = t;
        addr_i = addr; wdata_i = wd; exception_i = exc_in; d_rdata = $urandom;
        if (!access) begin
            push_cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, exc_exp, bad_exp, tag);
            step();
        end else begin
            rq.push_back(ref_req(st, t, addr, wd, tag));
            ld_exp = ref_load(rdata, addr[1:0], t);
            for (int c = 0; c <= a; c++) begin
                d_addr_ok = (c == a);
                d_rdata   = $urandom;
                push_cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0, tag);
                step();
            end
            d_addr_ok = 1'b0;
            for (int c = 1; c < b; c++) begin
                d_rdata = $urandom;
                push_cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0, tag);
                step();
            end
            d_data_ok  = 1'b1;
            d_rdata    = rdata;
            pipe_stall = (ps > 0);
            push_cyc(1'b0, 1'b0, ps == 0, ld, ld_exp, 4'd0, 32'h0, tag);
            step();
            d_data_ok = 1'b0;
            for (int k = 1; k <= ps; k++) begin
                pipe_stall = (k < ps);
                d_rdata    = $urandom;
                push_cyc(1'b0, 1'b0, k == ps, ld, ld_exp, 4'd0, 32'h0, {tag, " hold"});
                step();
            end
            pipe_stall = 1'b0;
        end
        clear_inputs();
    endtask

    // LW whose addr_ok comes after 3 cycles, then a flush in WAIT: response must be dropped.
    task automatic run_flush_case();
        clear_inputs();
        valid_i = 1'b1; MemRead_i = 1'b1; MemReadType_i = 3'd0; addr_i = 32'h0000_1000;
        rq.push_back(ref_req(1'b0, 3'd0, 32'h0000_1000, 32'h0, "flush lw"));
        for (int c = 0; c <= 3; c++) begin
            d_addr_ok = (c == 3);
            push_cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0, "flush req");
            step();
        end
        d_addr_ok = 1'b0;
        flush = 1'b1;
        push_cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0, "flush wait");
        step();
        clear_inputs();
        for (int c = 0; c < 2; c++) begin
            push_cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0, "flush cancel");
            step();
        end
        d_data_ok = 1'b1;
        d_rdata   = 32'h1234_5678;
        push_cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 4'd0, 32'h0, "flush drop");
        step();
        clear_inputs();
        push_cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 4'd0, 32'h0, "flush idle");
        step();
    endtask

    initial begin
        int          kind, a, b, ps;
        logic [2:0]  t;
        logic [31:0] addr;
        logic [3:0]  exc;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset stall_o", 32'(stall_o), 32'h0);
        check32("reset d_req", 32'(d_req), 32'h0);
        check32("reset load_data", load_data, 32'h0);
        check32("reset exception_o", 32'(exception_o), 32'h0);
        check32("reset bad_vaddr", bad_vaddr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr("lw best", 1, 3'd0, 32'h0000_1000, 32'h0, 4'd0, 0, 1, 0, 32'h8899_AABB);
        run_instr("lb", 1, 3'd3, 32'h0000_1003, 32'h0, 4'd0, 0, 1, 0, 32'h8011_2233);
        run_instr("lbu", 1, 3'd4, 32'h0000_1003, 32'h0, 4'd0, 1, 2, 0, 32'h8011_2233);
        run_instr("lh", 1, 3'd1, 32'h0000_1002, 32'h0, 4'd0, 0, 1, 0, 32'h8011_2233);
        run_instr("lhu", 1, 3'd2, 32'h0000_1000, 32'h0, 4'd0, 2, 1, 0, 32'h1234_F00D);
        run_instr("sb", 2, 3'd3, 32'h0000_2001, 32'h0000_00A5, 4'd0, 0, 1, 0, 32'h0);
        run_instr("sh", 2, 3'd1, 32'h0000_2002, 32'hDEAD_BEEF, 4'd0, 1, 1, 0, 32'h0);
        idle_cycle();
        run_instr("lw misaligned", 1, 3'd0, 32'h0000_1002, 32'h0, 4'd0, 0, 1, 0, 32'h0);
        run_instr("sh misaligned", 2, 3'd1, 32'h0000_3001, 32'h0, 4'd0, 0, 1, 0, 32'h0);
        run_instr("upstream exc", 1, 3'd0, 32'h0000_1002, 32'h0, 4'd3, 0, 1, 0, 32'h0);
        run_instr("nonmem", 0, 3'd0, 32'h0000_0003, 32'h0, 4'd0, 0, 1, 0, 32'h0);
        run_flush_case();
        run_instr("lw pipe_stall", 1, 3'd0, 32'h0000_1000, 32'h0, 4'd0, 0, 1, 3, 32'hCAFE_0001);
        idle_cycle();

        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 2));
            t    = 3'($urandom_range(0, 4));
            addr = $urandom;
            exc  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            a    = int'($urandom_range(0, 3));
            b    = int'($urandom_range(1, 3));
            ps   = int'($urandom_range(0, 2));
            run_instr("rand", kind, t, addr, $urandom, exc, a, b, ps, $urandom);
            if ($urandom_range(0, 1) == 1) begin
                idle_cycle();
            end
        end

        repeat (3) idle_cycle();
        @(negedge clk);
        check32("requests outstanding at end", 32'(rq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
